// File: rtl/interval_timer.sv
// Programmable interval timer: prescaled tick-enable plus a loadable tick counter
// with a one-cycle overflow pulse (one-shot or periodic). Optional TIMER_PAUSE_EN adds i_PAUSE.
module interval_timer #(
  parameter int PRESCALE = 50000,
  parameter int CNT_W    = 16
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_START,
  input  logic             i_STOP,
`ifdef TIMER_PAUSE_EN
  input  logic             i_PAUSE,
`endif
  input  logic             i_MODE,
  input  logic [CNT_W-1:0] i_LIM,
  output logic             o_TICK,
  output logic             o_OVERFLOW,
  output logic             o_BUSY,
  output logic [CNT_W-1:0] o_COUNT
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t           state, state_next;
  logic [PW-1:0]    prescaler;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] lim_reg;
  logic             mode_reg;
  logic             paused;
  logic             tick;
  logic             terminal;

`ifdef TIMER_PAUSE_EN
  assign paused = i_PAUSE;
`else
  assign paused = 1'b0;
`endif

  assign terminal = (count == lim_reg - CNT_W'(1));
  assign o_COUNT  = count;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) state <= IDLE;
    else       state <= state_next;
  end

  // Priority: stop, then start, then tick-driven completion.
  always_comb begin
    // NOTE: default first so every path assigns state_next; otherwise a latch is inferred.
    state_next = state;
    if (i_STOP) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (i_START) state_next = LOAD;
        LOAD:    state_next = RUN;
        RUN: begin
          if (i_START)                           state_next = LOAD;
          else if (tick && terminal && !mode_reg) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    o_BUSY = (state != IDLE);
    tick   = (state == RUN) && !paused && (prescaler == PS_LAST);
    o_TICK = tick;
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      prescaler  <= '0;
      count      <= '0;
      lim_reg    <= CNT_W'(1);
      mode_reg   <= 1'b0;
      o_OVERFLOW <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values; the later
      // assignment in this block overrides this default without ordering hazards.
      o_OVERFLOW <= 1'b0;
      if (i_STOP) begin
        prescaler <= '0;
        count     <= '0;
      end else begin
        case (state)
          LOAD: begin
            lim_reg   <= (i_LIM == '0) ? CNT_W'(1) : i_LIM;
            mode_reg  <= i_MODE;
            prescaler <= '0;
            count     <= '0;
          end
          RUN: begin
            // A restart request freezes the datapath; LOAD reinitialises it next cycle.
            if (!i_START && !paused) begin
              prescaler <= (prescaler == PS_LAST) ? '0 : prescaler + PW'(1);
              if (tick) begin
                if (terminal) begin
                  count      <= '0;
                  o_OVERFLOW <= 1'b1;
                end else begin
                  count <= count + CNT_W'(1);
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_interval_timer.sv
// Bench for interval_timer: two instances (PRESCALE 4 and 1) share random stimulus and are
// compared each cycle against an elapsed-time model; directed runs pin literal cycle numbers.
module tb_interval_timer;

  localparam int CW  = 8;
  localparam int PS0 = 4;
  localparam int PS1 = 1;
  localparam int NI  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          pause = 1'b0;
  logic          mode = 1'b0;
  logic [CW-1:0] lim = '0;

  logic          tick4, ovf4, busy4;
  logic [CW-1:0] count4;
  logic          tick1, ovf1, busy1;
  logic [CW-1:0] count1;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int base     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  interval_timer #(.PRESCALE(PS0), .CNT_W(CW)) dut4 (
    .i_CLK(clk), .i_RST(rst), .i_START(start), .i_STOP(stop),
`ifdef TIMER_PAUSE_EN
    .i_PAUSE(pause),
`endif
    .i_MODE(mode), .i_LIM(lim),
    .o_TICK(tick4), .o_OVERFLOW(ovf4), .o_BUSY(busy4), .o_COUNT(count4)
  );

  interval_timer #(.PRESCALE(PS1), .CNT_W(CW)) dut1 (
    .i_CLK(clk), .i_RST(rst), .i_START(start), .i_STOP(stop),
`ifdef TIMER_PAUSE_EN
    .i_PAUSE(pause),
`endif
    .i_MODE(mode), .i_LIM(lim),
    .o_TICK(tick1), .o_OVERFLOW(ovf1), .o_BUSY(busy1), .o_COUNT(count1)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
  endtask

  // Model: per instance, phase (0 idle, 1 load, 2 run) and unpaused cycles elapsed in the
  // current interval; tick and count follow from division by the prescale.
  int m_st[NI], m_e[NI], m_lim[NI], m_hold[NI];
  bit m_mode[NI], m_ovf[NI];

  function automatic int ps_of(int k);
    return (k == 0) ? PS0 : PS1;
  endfunction

  function automatic bit exp_tick(int k);
    return (m_st[k] == 2) && !pause && ((m_e[k] % ps_of(k)) == ps_of(k) - 1);
  endfunction

  function automatic int exp_count(int k);
    if (m_st[k] == 2) return m_e[k] / ps_of(k);
    if (m_st[k] == 1) return m_hold[k];
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NI; k++) begin
        m_st[k] = 0; m_e[k] = 0; m_lim[k] = 1; m_hold[k] = 0; m_mode[k] = 0; m_ovf[k] = 0;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        bit tk;
        int cnt;
        tk = exp_tick(k);
        cnt = exp_count(k);
        m_ovf[k] = 0;
        if (stop) begin
          m_st[k] = 0; m_e[k] = 0; m_hold[k] = 0;
        end else if (m_st[k] == 0) begin
          if (start) begin m_st[k] = 1; m_hold[k] = 0; end
        end else if (m_st[k] == 1) begin
          m_st[k] = 2; m_e[k] = 0;
          m_lim[k] = (lim == 0) ? 1 : int'(lim);
          m_mode[k] = mode;
        end else begin
          if (start) begin
            m_st[k] = 1; m_hold[k] = cnt;
          end else if (tk && ((m_e[k] + 1) % (m_lim[k] * ps_of(k)) == 0)) begin
            m_ovf[k] = 1; m_e[k] = 0;
            if (!m_mode[k]) m_st[k] = 0;
          end else if (!pause) begin
            m_e[k] = m_e[k] + 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check("tick4",  tick4,  exp_tick(0));
    check("ovf4",   ovf4,   m_ovf[0]);
    check("busy4",  busy4,  m_st[0] != 0);
    check("count4", count4, exp_count(0));
    check("tick1",  tick1,  exp_tick(1));
    check("ovf1",   ovf1,   m_ovf[1]);
    check("busy1",  busy1,  m_st[1] != 0);
    check("count1", count1, exp_count(1));
  end

  task automatic sync_to(input int r);
    while ((cyc - base) < r) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  busy4,  0);
    check("rst_count", count4, 0);
    check("rst_ovf",   ovf4,   0);
    check("rst_tick",  tick1,  0);
    rst = 1'b0;
    @(posedge clk); #1;

    // One-shot, lim 3, start in relative cycle 10.
    base = cyc; lim = 3; mode = 0;
    for (int r = 10; r <= 26; r++) begin
      sync_to(r);
      start = (r == 10);
      @(negedge clk);
      if (r >= 11) begin
        check("os_busy4", busy4, (r <= 23));
        check("os_tick4", tick4, (r == 15 || r == 19 || r == 23));
        check("os_ovf4",  ovf4,  (r == 24));
        check("os_ovf1",  ovf1,  (r == 15));
      end
    end

    // Periodic, lim 2, stop on the dut4 terminal tick in relative cycle 25.
    base = cyc; lim = 2; mode = 1; start = 1;
    for (int r = 1; r <= 26; r++) begin
      sync_to(r);
      start = 0;
      stop = (r == 25);
      @(negedge clk);
      check("per_ovf4", ovf4, (r == 10 || r == 18));
      check("per_ovf1", ovf1, (r >= 4 && r <= 24 && r % 2 == 0));
      if (r >= 2 && r <= 25) begin
        check("per_cnt4", count4, ((r - 2) / 4) % 2);
        check("per_cnt1", count1, (r - 2) % 2);
      end
      if (r == 26) begin
        check("stop_busy4",  busy4,  0);
        check("stop_count4", count4, 0);
        check("stop_busy1",  busy1,  0);
      end
    end

    // Zero limit behaves as one.
    base = cyc; lim = 0; mode = 0; start = 1;
    for (int r = 1; r <= 8; r++) begin
      sync_to(r);
      start = 0;
      @(negedge clk);
      check("lim0_ovf1", ovf1, (r == 3));
      check("lim0_ovf4", ovf4, (r == 6));
    end

    // Restart during RUN at relative cycle 7 with a new limit.
    base = cyc; lim = 3; mode = 0; start = 1;
    for (int r = 1; r <= 16; r++) begin
      sync_to(r);
      start = (r == 7);
      lim = (r >= 7) ? 8'd1 : 8'd3;
      @(negedge clk);
      check("rs_ovf4", ovf4, (r == 13));
      check("rs_ovf1", ovf1, (r == 5 || r == 10));
      if (r == 8) check("rs_busy4", busy4, 1);
    end

    // Asynchronous reset between clock edges in the middle of a run.
    base = cyc; lim = 5; mode = 1; start = 1;
    sync_to(1);
    start = 0;
    sync_to(8);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy4",  busy4,  0);
    check("arst_count4", count4, 0);
    check("arst_tick4",  tick4,  0);
    check("arst_count1", count1, 0);
    check("arst_busy1",  busy1,  0);
    #3 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("post_busy4",  busy4,  0);
    check("post_count1", count1, 0);

`ifdef TIMER_PAUSE_EN
    // Pause for relative cycles 13..17 stretches the interval by five cycles.
    base = cyc; lim = 3; mode = 0;
    for (int r = 10; r <= 31; r++) begin
      sync_to(r);
      start = (r == 10);
      pause = (r >= 13 && r <= 17);
      @(negedge clk);
      if (r >= 11) check("pause_ovf4", ovf4, (r == 29));
    end
    pause = 0;
`endif

    // Random traffic checked by the per-cycle compare process.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 19) == 0);
      stop  = ($urandom_range(0, 79) == 0);
      lim   = CW'($urandom_range(0, 6));
      mode  = 1'($urandom_range(0, 1));
`ifdef TIMER_PAUSE_EN
      pause = ($urandom_range(0, 4) == 0);
`endif
    end
    start = 0; stop = 0; pause = 0;
    repeat (4) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
